hamming_weight_enum: RTL and testbench



---
 rtl/hamming_weight_enum_pkg.sv | 33 +++
 rtl/hamming_weight_enum_gosper_next.sv | 34 +++
 rtl/hamming_weight_enum.sv | 135 +++++++++++++
 tb/tb_hamming_weight_enum.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_weight_enum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_weight_enum_pkg
// Description : Shared widths, FSM state type and weight-mask helpers for the
//               fixed-weight word enumerator.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_weight_enum_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest word of weight k: k ones packed at the bottom.
    function automatic logic [WORD_W-1:0] first_mask(input logic [3:0] k);
        logic [WORD_W:0] m;
        m = (9'd1 << k) - 9'd1;
        return m[WORD_W-1:0];
    endfunction

    // Largest word of weight k: k ones packed at the top.
    function automatic logic [WORD_W-1:0] last_mask(input logic [3:0] k);
        logic [2*WORD_W-1:0] t;
        t = {8'h00, first_mask(k)} << (4'd8 - k);
        return t[WORD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_weight_enum_gosper_next.sv
`default_nettype none
// ============================================================================
// Module      : gosper_next
// Description : Combinational next-larger word with identical popcount
//               (Gosper's hack) for 8-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module gosper_next
    import hamming_weight_enum_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] nxt
);

    logic [WORD_W-1:0] w_c;
    logic [WORD_W:0]   w_r;
    logic [WORD_W:0]   w_diff;
    logic [2:0]        w_ctz;

    // Downward scan leaves the index of the lowest set bit.
    always_comb begin
        w_ctz = 3'd0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (x[i]) w_ctz = 3'(i);
        end
    end

    assign w_c    = x & (~x + 8'd1);
    assign w_r    = {1'b0, x} + {1'b0, w_c};
    assign w_diff = w_r ^ {1'b0, x};
    assign nxt    = w_r[WORD_W-1:0] | 8'((w_diff >> 2) >> w_ctz);

endmodule
`default_nettype wire

// File: rtl/hamming_weight_enum.sv
`default_nettype none
// ============================================================================
// Module      : hamming_weight_enum
// Description : Streams every 8-bit word of popcount k in ascending order over
//               a valid/ready handshake. Define HAMMING_ENUM_SELFCHECK_EN to
//               build the sticky popcount/ordering checker behind chk_err.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_weight_enum
    import hamming_weight_enum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        weight,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              chk_err
);

    state_t              r_state;
    logic [3:0]          r_k;
    logic [WORD_W-1:0]   r_x;
    logic [IDX_W-1:0]    r_idx;
    logic                r_last;
    logic                r_done;
    logic                r_err;
    logic [WORD_W-1:0]   w_next;

    gosper_next u_next (
        .x   (r_x),
        .nxt (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 4'd0;
            r_x     <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (weight > 4'd8) begin
                            r_err <= 1'b1;
                        end else begin
                            r_k     <= weight;
                            r_x     <= first_mask(weight);
                            r_idx   <= '0;
                            // Weights 0 and 8 have a single word.
                            r_last  <= (weight == 4'd0) || (weight == 4'd8);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_x    <= w_next;
                            r_idx  <= r_idx + 7'd1;
                            r_last <= (w_next == last_mask(r_k));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == RUN);
    assign busy      = (r_state == RUN);
    assign out_word  = r_x;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign done      = r_done;
    assign err       = r_err;

`ifdef HAMMING_ENUM_SELFCHECK_EN
    logic [3:0]        w_pop;
    logic [WORD_W-1:0] r_prev;
    logic              r_prev_vld;
    logic              r_chk_err;

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < WORD_W; i++) begin
            w_pop = w_pop + {3'd0, r_x[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && start && weight <= 4'd8) begin
                r_prev_vld <= 1'b0;
            end else if (out_valid && out_ready && !abort) begin
                r_prev     <= r_x;
                r_prev_vld <= 1'b1;
            end
            if (out_valid && ((w_pop != r_k) || (r_prev_vld && r_x <= r_prev))) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_weight_enum.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_weight_enum
// Description : Self-checking bench: vector table of weights, randomized
//               handshake runs against a brute-force popcount model, plus
//               err, abort, back-to-back and mid-run reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_weight_enum;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] weight;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_word;
    logic [6:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;
    logic       chk_err;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int got_q[$];

    typedef struct {
        int         k;
        int         count;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    hamming_weight_enum dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .weight    (weight),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .chk_err   (chk_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sequence: every byte with popcount k, in ascending order.
    task automatic build_ref(input int k);
        exp_q.delete();
        for (int w = 0; w < 256; w++) begin
            if ($countones(w[7:0]) == k) exp_q.push_back(w);
        end
    endtask

    // Runs one enumeration to completion; returns in the done cycle.
    task automatic run(input int k, input bit rnd_ready, input string tag);
        int         n = 0;
        int         cyc = 0;
        bit         fin = 0;
        bit         stalled = 0;
        logic [7:0] hw = '0;
        logic [6:0] hi = '0;
        build_ref(k);
        got_q.delete();
        start  = 1'b1;
        weight = 4'(k);
        step();
        start  = 1'b0;
        chk($sformatf("%s busy_after_start", tag), 32'(busy), 32'd1);
        chk($sformatf("%s valid_after_start", tag), 32'(out_valid), 32'd1);
        while (!fin && cyc < 1000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk($sformatf("%s stall_word", tag), 32'(out_word), 32'(hw));
                chk($sformatf("%s stall_idx", tag), 32'(out_idx), 32'(hi));
            end
            if (!out_valid) begin
                chk($sformatf("%s valid_dropped n=%0d", tag, n), 32'(out_valid), 32'd1);
                fin = 1;
            end else if (out_ready) begin
                if (n < exp_q.size()) begin
                    chk($sformatf("%s word n=%0d", tag, n), 32'(out_word), 32'(exp_q[n]));
                    chk($sformatf("%s idx n=%0d", tag, n), 32'(out_idx), 32'(n));
                    chk($sformatf("%s last n=%0d", tag, n), 32'(out_last),
                        32'(n == exp_q.size() - 1));
                end else begin
                    chk($sformatf("%s extra_word n=%0d", tag, n), 32'(n), 32'(exp_q.size() - 1));
                    fin = 1;
                end
                got_q.push_back(int'(out_word));
                n++;
                stalled = 0;
                if (out_last) fin = 1;
            end else begin
                stalled = 1;
                hw = out_word;
                hi = out_idx;
            end
            if (fin) out_ready = out_ready;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (!fin) chk($sformatf("%s timeout", tag), 32'(cyc), 32'd0);
        chk($sformatf("%s count", tag), 32'(n), 32'(exp_q.size()));
        chk($sformatf("%s done_pulse", tag), 32'(done), 32'd1);
        chk($sformatf("%s busy_in_done", tag), 32'(busy), 32'd0);
        chk($sformatf("%s valid_in_done", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s chk_err", tag), 32'(chk_err), 32'd0);
    endtask

    task automatic wait_idx(input int target, input string tag);
        int cyc = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_idx == 7'(target)) && cyc < 300) begin
            step();
            cyc++;
        end
        chk($sformatf("%s reached_idx", tag), 32'(out_idx), 32'(target));
    endtask

    initial begin
        vecs[0] = '{k: 4, count: 70, first: 8'h0F, last: 8'hF0};
        vecs[1] = '{k: 0, count: 1,  first: 8'h00, last: 8'h00};
        vecs[2] = '{k: 8, count: 1,  first: 8'hFF, last: 8'hFF};
        vecs[3] = '{k: 1, count: 8,  first: 8'h01, last: 8'h80};
        vecs[4] = '{k: 2, count: 28, first: 8'h03, last: 8'hC0};
        vecs[5] = '{k: 7, count: 8,  first: 8'h7F, last: 8'hFE};

        rst = 1'b1; start = 1'b0; weight = 4'd0; abort = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_word", 32'(out_word), 32'd0);
        chk("reset out_idx", 32'(out_idx), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset chk_err", 32'(chk_err), 32'd0);
        rst = 1'b0;
        step();

        // Table-driven full runs at full throughput.
        for (int v = 0; v < 6; v++) begin
            run(vecs[v].k, 1'b0, $sformatf("vec k=%0d", vecs[v].k));
            chk($sformatf("vec k=%0d table_count", vecs[v].k), 32'(got_q.size()), 32'(vecs[v].count));
            if (got_q.size() > 0) begin
                chk($sformatf("vec k=%0d table_first", vecs[v].k), 32'(got_q[0]), 32'(vecs[v].first));
                chk($sformatf("vec k=%0d table_last", vecs[v].k), 32'(got_q[got_q.size()-1]),
                    32'(vecs[v].last));
            end
            if (vecs[v].k == 4 && got_q.size() > 2) begin
                chk("k4 second_word", 32'(got_q[1]), 32'h17);
                chk("k4 third_word", 32'(got_q[2]), 32'h1B);
            end
            step();
            chk($sformatf("vec k=%0d done_one_cycle", vecs[v].k), 32'(done), 32'd0);
        end

        // Random backpressure, including the k=1 stall sequence.
        run(1, 1'b1, "stall k=1");
        step();
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 8)), 1'b1, $sformatf("rand%0d", r));
            step();
        end

        // Back-to-back: start in the done cycle.
        run(2, 1'b0, "b2b first");
        start = 1'b1; weight = 4'd3;
        step();
        start = 1'b0;
        chk("b2b valid", 32'(out_valid), 32'd1);
        chk("b2b word", 32'(out_word), 32'h07);
        chk("b2b idx", 32'(out_idx), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Illegal weight.
        start = 1'b1; weight = 4'd9;
        step();
        start = 1'b0;
        chk("err pulse", 32'(err), 32'd1);
        chk("err busy", 32'(busy), 32'd0);
        chk("err valid", 32'(out_valid), 32'd0);
        step();
        chk("err one_cycle", 32'(err), 32'd0);
        chk("err still_idle", 32'(out_valid), 32'd0);

        // Abort at idx 10, then restart.
        start = 1'b1; weight = 4'd3;
        step();
        start = 1'b0;
        wait_idx(10, "abort");
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort no_done", 32'(done), 32'd0);
        step();
        chk("abort no_done_late", 32'(done), 32'd0);
        start = 1'b1; weight = 4'd3;
        step();
        start = 1'b0;
        chk("restart word", 32'(out_word), 32'h07);
        chk("restart idx", 32'(out_idx), 32'd0);
        chk("restart valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Reset mid-run.
        start = 1'b1; weight = 4'd5;
        step();
        start = 1'b0;
        wait_idx(20, "midrst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_word", 32'(out_word), 32'd0);
        chk("midrst out_idx", 32'(out_idx), 32'd0);
        chk("midrst out_last", 32'(out_last), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst err", 32'(err), 32'd0);
        chk("midrst chk_err", 32'(chk_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
